// File: rtl/uart_pkg.sv
// Shared types and constants for the miner UART / display front end.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // 100 MHz system clock, 115200 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned DEFAULT_REFRESH_BITS = 17;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a}, dp off
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_LUT[nibble];
  endfunction

endpackage

// File: rtl/uart_core_seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner; anodes and cathodes registered.
module seg7_scan
  import uart_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = DEFAULT_REFRESH_BITS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] word,
  output logic [7:0]  ca,
  output logic [7:0]  an
);

  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic [2:0]              idx_q, idx_d;
  logic [7:0]              ca_q, ca_d;
  logic [7:0]              an_q, an_d;

  // Next refresh count, digit index and the segment/anode image of the current digit
  always_comb begin
    refresh_d = refresh_q + REFRESH_BITS'(1);
    idx_d     = idx_q;
    if (refresh_q == '1) begin
      idx_d = idx_q + 3'd1;
    end
    an_d = ~(8'd1 << idx_q);
    ca_d = hex_to_seg(word[{idx_q, 2'b00} +: 4]);
  end

  // Scan state and display output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_q <= '0;
      idx_q     <= '0;
      an_q      <= 8'hFE;
      ca_q      <= 8'hC0;
    end else begin
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      ca_q      <= ca_d;
    end
  end

  assign ca = ca_q;
  assign an = an_q;

endmodule

// File: rtl/uart_core.sv
// UART RX/TX and display front end of the FPGA miner.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned REFRESH_BITS = DEFAULT_REFRESH_BITS
) (
  input  logic       clock,
  input  logic       reset,
  output logic       txd,
  input  logic       rxd,
  output logic [7:0] ca,
  output logic [7:0] an,
  input  logic       nonce_we,
  input  logic       transmit_data,
  input  logic       display_toggle,
  output logic       error
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // RX side
  logic             rxd_meta_q, rxd_sync_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [31:0]      rx_word_q, rx_word_d;
  logic             error_q, error_d;
  logic [31:0]      nonce_q, nonce_d;

  // TX side
  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [1:0]       tx_byte_q, tx_byte_d;
  logic [31:0]      tx_buf_q, tx_buf_d;
  logic             txd_q, txd_d;
  logic [7:0]       tx_cur_byte;

  logic [31:0]      disp_word;

  // Two-flop synchronizer for the asynchronous serial input
  always_ff @(posedge clock) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  // Receiver FSM: mid-bit sampling, bytes shifted into rx_word on a good stop bit
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_word_d  = rx_word_q;
    error_d    = error_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rxd_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rxd_sync_q) begin
            rx_word_d = {rx_word_q[23:0], rx_shift_q};
          end else begin
            error_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Nonce load uses the pre-update rx_word when a byte lands in the same cycle
  always_comb begin
    nonce_d = nonce_we ? rx_word_q : nonce_q;
  end

  assign tx_cur_byte = tx_buf_q[31:24];

  // Transmitter FSM: txd is registered, so each transition computes the next line level
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tx_buf_d   = tx_buf_q;
    txd_d      = txd_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (transmit_data) begin
          tx_buf_d   = nonce_q;
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_byte_d  = '0;
          txd_d      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
          txd_d      = tx_cur_byte[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            txd_d    = tx_cur_byte[tx_bit_q + 3'd1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_byte_q == 2'd3) begin
            tx_state_d = TX_IDLE;
            txd_d      = 1'b1;
          end else begin
            tx_byte_d  = tx_byte_q + 2'd1;
            tx_buf_d   = {tx_buf_q[23:0], 8'h00};
            tx_state_d = TX_START;
            txd_d      = 1'b0;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        txd_d      = 1'b1;
      end
    endcase
  end

  // RX, nonce and TX state registers; reset aborts any frame in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_word_q  <= '0;
      error_q    <= 1'b0;
      nonce_q    <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_buf_q   <= '0;
      txd_q      <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_word_q  <= rx_word_d;
      error_q    <= error_d;
      nonce_q    <= nonce_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_buf_q   <= tx_buf_d;
      txd_q      <= txd_d;
    end
  end

  assign disp_word = display_toggle ? rx_word_q : nonce_q;

  seg7_scan #(
    .REFRESH_BITS(REFRESH_BITS)
  ) u_scan (
    .clock (clock),
    .reset (reset),
    .word  (disp_word),
    .ca    (ca),
    .an    (an)
  );

  assign txd   = txd_q;
  assign error = error_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed testbench for uart_core with CLKS_PER_BIT=4, REFRESH_BITS=3.
module tb_uart_core;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       nonce_we = 1'b0;
  logic       transmit_data = 1'b0;
  logic       display_toggle = 1'b0;
  logic       txd;
  logic       error;
  logic [7:0] ca;
  logic [7:0] an;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  uart_core #(
    .CLKS_PER_BIT(4),
    .REFRESH_BITS(3)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .txd            (txd),
    .rxd            (rxd),
    .ca             (ca),
    .an             (an),
    .nonce_we       (nonce_we),
    .transmit_data  (transmit_data),
    .display_toggle (display_toggle),
    .error          (error)
  );

  // Drive one 8N1 byte on rxd (4 clocks per bit), followed by idle time
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clock);
    rxd = 1'b0;
    repeat (4) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (4) @(negedge clock);
    end
    rxd = stop_bit;
    repeat (4) @(negedge clock);
    rxd = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  task automatic pulse_nonce_we();
    @(negedge clock);
    nonce_we = 1'b1;
    @(negedge clock);
    nonce_we = 1'b0;
  endtask

  // Start a transmission and sample all 40 bits mid-bit; optionally poke
  // transmit_data and nonce_we while the frame is in flight
  task automatic tx_frame(input int poke_bit, output logic [31:0] got, output int bad);
    int k;
    bad = 0;
    got = '0;
    @(negedge clock);
    transmit_data = 1'b1;
    @(negedge clock);
    transmit_data = 1'b0;
    if (txd !== 1'b0) bad++;
    for (int b = 0; b < 40; b++) begin
      repeat ((b == 0) ? 1 : 4) @(negedge clock);
      transmit_data = 1'b0;
      nonce_we      = 1'b0;
      k = b % 10;
      if (k == 0) begin
        if (txd !== 1'b0) bad++;
      end else if (k == 9) begin
        if (txd !== 1'b1) bad++;
      end else begin
        got[(3 - b / 10) * 8 + k - 1] = txd;
      end
      if (b == poke_bit) begin
        transmit_data = 1'b1;
        nonce_we      = 1'b1;
      end
    end
    repeat (3) @(negedge clock);
    if (txd !== 1'b1) bad++;
  endtask

  // Wait for the anode pattern to switch to target (first cycle of that digit)
  task automatic wait_digit(input logic [7:0] target, output bit ok);
    logic [7:0] prev;
    ok   = 1'b0;
    prev = an;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      if (an === target && prev !== target) ok = 1'b1;
      prev = an;
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    bit stayed = 1'b1;
    repeat (cycles) begin
      @(negedge clock);
      if (txd !== 1'b1) stayed = 1'b0;
    end
    tests++;
    if (stayed !== 1'b1) begin
      fails++;
      $display("FAIL %s: txd left idle (got 0, want 1 for %0d cycles)", name, cycles);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tests++;
    if (txd !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b want 1", txd); end
    tests++;
    if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", error); end
    tests++;
    if (an !== 8'hFE) begin fails++; $display("FAIL reset_an: got %h want fe", an); end
    tests++;
    if (ca !== 8'hC0) begin fails++; $display("FAIL reset_ca: got %h want c0", ca); end
    reset = 1'b0;
    check_idle("reset_no_tx", 50);
  endtask

  task automatic test_tx_zero();
    logic [31:0] got;
    int bad;
    tx_frame(-1, got, bad);
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL tx_zero_framing: got %0d bad bits want 0", bad); end
    tests++;
    if (got !== 32'h0000_0000) begin fails++; $display("FAIL tx_zero_data: got %h want 00000000", got); end
    check_idle("tx_zero_idle", 40);
  endtask

  task automatic test_rx_load();
    logic [31:0] got;
    int bad;
    bit ok;
    logic [7:0] tgt;
    logic [7:0] exp_ca [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    // short low glitch must be rejected without a framing error
    @(negedge clock);
    rxd = 1'b0;
    @(negedge clock);
    rxd = 1'b1;
    repeat (10) @(negedge clock);
    tests++;
    if (error !== 1'b0) begin fails++; $display("FAIL glitch_error: got %b want 0", error); end
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    pulse_nonce_we();
    tx_frame(-1, got, bad);
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL rx_load_framing: got %0d bad bits want 0", bad); end
    tests++;
    if (got !== 32'h1234_5678) begin fails++; $display("FAIL rx_load_data: got %h want 12345678", got); end
    display_toggle = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tgt = ~(8'd1 << k);
      wait_digit(tgt, ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL digit%0d_an: timeout waiting for an=%h (got %h)", k, tgt, an);
      end else if (ca !== exp_ca[k]) begin
        fails++;
        $display("FAIL digit%0d_ca: got %h want %h", k, ca, exp_ca[k]);
      end
    end
  endtask

  task automatic test_framing();
    logic [31:0] got;
    int bad;
    send_byte(8'hAB, 1'b0);
    tests++;
    if (error !== 1'b1) begin fails++; $display("FAIL framing_error_set: got %b want 1", error); end
    send_byte(8'h9A, 1'b1);
    tests++;
    if (error !== 1'b1) begin fails++; $display("FAIL framing_error_sticky: got %b want 1", error); end
    pulse_nonce_we();
    tx_frame(-1, got, bad);
    tests++;
    if (got !== 32'h3456_789A || bad !== 0) begin
      fails++;
      $display("FAIL framing_discard: got %h (%0d bad bits) want 3456789a", got, bad);
    end
  endtask

  task automatic test_toggle();
    bit ok;
    // rx_word becomes 56789AC5 while nonce stays 3456789A
    send_byte(8'hC5, 1'b1);
    display_toggle = 1'b0;
    wait_digit(8'hFE, ok);
    tests++;
    if (!ok || ca !== 8'h88) begin fails++; $display("FAIL toggle_d0_nonce: got an=%h ca=%h want fe/88", an, ca); end
    display_toggle = 1'b1;
    repeat (2) @(negedge clock);
    tests++;
    if (an !== 8'hFE || ca !== 8'h92) begin fails++; $display("FAIL toggle_d0_rx: got an=%h ca=%h want fe/92", an, ca); end
    wait_digit(8'hFD, ok);
    tests++;
    if (!ok || ca !== 8'hC6) begin fails++; $display("FAIL toggle_d1_rx: got an=%h ca=%h want fd/c6", an, ca); end
    display_toggle = 1'b0;
    repeat (2) @(negedge clock);
    tests++;
    if (an !== 8'hFD || ca !== 8'h90) begin fails++; $display("FAIL toggle_d1_nonce: got an=%h ca=%h want fd/90", an, ca); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    int bad;
    bit ok;
    // transmit_data and nonce_we mid-frame: ignored / does not disturb frame
    tx_frame(12, got, bad);
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL busy_framing: got %0d bad bits want 0", bad); end
    tests++;
    if (got !== 32'h3456_789A) begin fails++; $display("FAIL busy_data: got %h want 3456789a", got); end
    check_idle("busy_no_second_frame", 60);
    display_toggle = 1'b0;
    wait_digit(8'hFE, ok);
    tests++;
    if (!ok || ca !== 8'h92) begin fails++; $display("FAIL busy_nonce_reload: got an=%h ca=%h want fe/92", an, ca); end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clock);
    transmit_data = 1'b1;
    @(negedge clock);
    transmit_data = 1'b0;
    tests++;
    if (txd !== 1'b0) begin fails++; $display("FAIL midreset_start: got %b want 0", txd); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (txd !== 1'b1) begin fails++; $display("FAIL midreset_txd: got %b want 1", txd); end
    tests++;
    if (error !== 1'b0) begin fails++; $display("FAIL midreset_error: got %b want 0", error); end
    tests++;
    if (an !== 8'hFE || ca !== 8'hC0) begin fails++; $display("FAIL midreset_display: got an=%h ca=%h want fe/c0", an, ca); end
    reset = 1'b0;
    check_idle("midreset_aborted", 60);
  endtask

  initial begin
    test_reset();
    test_tx_zero();
    test_rx_load();
    test_framing();
    test_toggle();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
